rf_dump_tx: RTL and testbench

- Read-side debug scanner for the CPU register file.
- On a start pulse it walks the file's debug select port from FIRST_REG to LAST_REG and captures each 32-bit word.
- It streams every captured word as bytes, MSB first, over a valid/ready byte interface.
- The byte stream feeds the board UART transmitter or a trace FIFO, so register contents can be dumped without halting the core.

---
 rtl/rf_dump_tx.sv | 145 ++++++++++++++
 tb/tb_rf_dump_tx.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/rf_dump_tx.sv
// Register file debug scanner: walks reg_sel over FIRST_REG..LAST_REG and streams each word MSB first.
// Define RF_DUMP_HDR_EN to prefix every word with a {3'b000, index} header byte.
//
// state | meaning
// IDLE  | waiting for start
// SEL   | reg_sel settling through the register file read mux
// CAP   | snapshot reg_data, present the first byte
// SEND  | byte handshakes on tx_valid/tx_ready
// DONE  | one-cycle done pulse, back to IDLE
module rf_dump_tx #(
   parameter int FIRST_REG = 0,
   parameter int LAST_REG  = 31
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic        busy,
   output logic        done,
   output logic [4:0]  reg_sel,
   input  logic [31:0] reg_data,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready
);

   localparam logic [4:0] FIRST_IDX = 5'(FIRST_REG);
   localparam logic [4:0] LAST_IDX  = 5'(LAST_REG);
`ifdef RF_DUMP_HDR_EN
   localparam logic [2:0] LAST_BYTE = 3'd4;
`else
   localparam logic [2:0] LAST_BYTE = 3'd3;
`endif

   typedef enum logic [2:0] {IDLE, SEL, CAP, SEND, DONE} state_t;

   state_t      state, state_nxt;
   logic [4:0]  idx, idx_nxt;
   logic [2:0]  cnt, cnt_nxt;
   logic [31:0] shadow, shadow_nxt;
   logic [4:0]  reg_sel_nxt;
   logic [7:0]  tx_data_nxt;
   logic        tx_valid_nxt;
   logic        busy_nxt;
   logic        done_nxt;

   function automatic logic [7:0] word_byte(input logic [31:0] word, input logic [2:0] k);
      case (k)
         3'd0:    word_byte = word[31:24];
         3'd1:    word_byte = word[23:16];
         3'd2:    word_byte = word[15:8];
         default: word_byte = word[7:0];
      endcase
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         idx      <= 5'd0;
         cnt      <= 3'd0;
         shadow   <= 32'd0;
         reg_sel  <= 5'd0;
         tx_data  <= 8'd0;
         tx_valid <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         state    <= state_nxt;
         idx      <= idx_nxt;
         cnt      <= cnt_nxt;
         shadow   <= shadow_nxt;
         reg_sel  <= reg_sel_nxt;
         tx_data  <= tx_data_nxt;
         tx_valid <= tx_valid_nxt;
         busy     <= busy_nxt;
         done     <= done_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      idx_nxt      = idx;
      cnt_nxt      = cnt;
      shadow_nxt   = shadow;
      reg_sel_nxt  = reg_sel;
      tx_data_nxt  = tx_data;
      tx_valid_nxt = tx_valid;
      busy_nxt     = busy;
      done_nxt     = 1'b0;

      case (state)
         IDLE: begin
            if (start) begin
               idx_nxt     = FIRST_IDX;
               reg_sel_nxt = FIRST_IDX;
               busy_nxt    = 1'b1;
               state_nxt   = SEL;
            end
         end
         SEL: state_nxt = CAP;
         CAP: begin
            shadow_nxt   = reg_data;
            cnt_nxt      = 3'd0;
`ifdef RF_DUMP_HDR_EN
            tx_data_nxt  = {3'b000, idx};
`else
            tx_data_nxt  = reg_data[31:24];
`endif
            tx_valid_nxt = 1'b1;
            state_nxt    = SEND;
         end
         SEND: begin
            if (tx_valid && tx_ready) begin
               if (cnt < LAST_BYTE) begin
                  cnt_nxt     = cnt + 3'd1;
                  // with a header, counter value n is followed by data byte n-1+1 = n
`ifdef RF_DUMP_HDR_EN
                  tx_data_nxt = word_byte(shadow, cnt);
`else
                  tx_data_nxt = word_byte(shadow, cnt + 3'd1);
`endif
               end else if (idx < LAST_IDX) begin
                  tx_valid_nxt = 1'b0;
                  idx_nxt      = idx + 5'd1;
                  reg_sel_nxt  = idx + 5'd1;
                  state_nxt    = SEL;
               end else begin
                  tx_valid_nxt = 1'b0;
                  busy_nxt     = 1'b0;
                  done_nxt     = 1'b1;
                  reg_sel_nxt  = 5'd0;
                  state_nxt    = DONE;
               end
            end
         end
         DONE: state_nxt = IDLE;
         default: begin
            state_nxt    = IDLE;
            tx_valid_nxt = 1'b0;
            busy_nxt     = 1'b0;
            reg_sel_nxt  = 5'd0;
         end
      endcase
   end

endmodule

// File: tb/tb_rf_dump_tx.sv
// Bench for rf_dump_tx: three instances (full range, 5..6, single register 7) fed by a
// shared register file array; the expected byte stream is rebuilt from captured register values.
module tb_rf_dump_tx;
`ifdef RF_DUMP_HDR_EN
   localparam int BPR = 5;
   localparam int HB  = 1;
`else
   localparam int BPR = 4;
   localparam int HB  = 0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        tx_ready;
   logic        start_v  [3];
   logic        busy_v   [3];
   logic        done_v   [3];
   logic        txv_v    [3];
   logic [4:0]  sel_v    [3];
   logic [31:0] rdata_v  [3];
   logic [7:0]  txd_v    [3];
   logic [31:0] regs     [32];
   logic [31:0] cap      [32];
   logic [7:0]  got      [$];
   logic [7:0]  exp_q    [$];
   int          checks   = 0;
   int          errors   = 0;
   int          done_cnt = 0;
   logic        pv [3];
   logic [7:0]  pd [3];
   logic        pr;

   always #5 clk = ~clk;

   assign rdata_v[0] = (sel_v[0] == 5'd0) ? 32'd0 : regs[sel_v[0]];
   assign rdata_v[1] = (sel_v[1] == 5'd0) ? 32'd0 : regs[sel_v[1]];
   assign rdata_v[2] = (sel_v[2] == 5'd0) ? 32'd0 : regs[sel_v[2]];

   rf_dump_tx #(.FIRST_REG(0), .LAST_REG(31)) u_dut0 (
      .clk(clk), .rst(rst), .start(start_v[0]), .busy(busy_v[0]), .done(done_v[0]),
      .reg_sel(sel_v[0]), .reg_data(rdata_v[0]), .tx_data(txd_v[0]), .tx_valid(txv_v[0]),
      .tx_ready(tx_ready));
   rf_dump_tx #(.FIRST_REG(5), .LAST_REG(6)) u_dut1 (
      .clk(clk), .rst(rst), .start(start_v[1]), .busy(busy_v[1]), .done(done_v[1]),
      .reg_sel(sel_v[1]), .reg_data(rdata_v[1]), .tx_data(txd_v[1]), .tx_valid(txv_v[1]),
      .tx_ready(tx_ready));
   rf_dump_tx #(.FIRST_REG(7), .LAST_REG(7)) u_dut2 (
      .clk(clk), .rst(rst), .start(start_v[2]), .busy(busy_v[2]), .done(done_v[2]),
      .reg_sel(sel_v[2]), .reg_data(rdata_v[2]), .tx_data(txd_v[2]), .tx_valid(txv_v[2]),
      .tx_ready(tx_ready));

   function automatic int first_of(input int d);
      return (d == 0) ? 0 : (d == 1) ? 5 : 7;
   endfunction

   function automatic int last_of(input int d);
      return (d == 0) ? 31 : (d == 1) ? 6 : 7;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Inputs change #1 after posedge, so at negedge the next edge's handshake is already known.
   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (!rst) begin
            if (txv_v[i] && tx_ready) got.push_back(txd_v[i]);
            if (done_v[i]) done_cnt++;
            if (pv[i] && !pr) begin
               chk($sformatf("hold_valid_%0d", i), 32'(txv_v[i]), 32'd1);
               chk($sformatf("hold_data_%0d", i), 32'(txd_v[i]), 32'(pd[i]));
            end
            pv[i] = txv_v[i];
         end else begin
            pv[i] = 1'b0;
         end
         pd[i] = txd_v[i];
      end
      pr = tx_ready;
   end

   function automatic void build_exp(input int first, input int last);
      exp_q.delete();
      for (int r = first; r <= last; r++) begin
         logic [31:0] v;
         v = (r == 0) ? 32'd0 : cap[r];
         if (HB == 1) exp_q.push_back(8'(r));
         for (int b = 3; b >= 0; b--) exp_q.push_back(8'(v >> (8 * b)));
      end
   endfunction

   task automatic rand_regs();
      for (int i = 0; i < 32; i++) regs[i] = $urandom;
   endtask

   // mode 0: ready tied high, 1: random ready, 2: one cycle on / two off
   task automatic run_dump(input int d, input int mode, input bit poke, input bit snap,
                           input int abort_at);
      int n;
      int exp_cycles;
      bit snapped;
      exp_cycles = (last_of(d) - first_of(d) + 1) * (2 + BPR) + 1;
      got.delete();
      done_cnt = 0;
      snapped  = 1'b0;
      build_exp(first_of(d), last_of(d));
      tx_ready = 1'b1;
      @(posedge clk); #1;
      start_v[d] = 1'b1;
      n = 0;
      forever begin
         @(posedge clk); #1;
         n++;
         start_v[d] = poke && (n == 20);
         case (mode)
            0:       tx_ready = 1'b1;
            1:       tx_ready = 1'($urandom_range(0, 1));
            default: tx_ready = (n % 3 == 0);
         endcase
         if (n == 1) begin
            chk("busy_after_start", 32'(busy_v[d]), 32'd1);
            chk("valid_in_sel", 32'(txv_v[d]), 32'd0);
            chk("sel_first", 32'(sel_v[d]), 32'(first_of(d)));
         end
         if (n == 2) chk("valid_in_cap", 32'(txv_v[d]), 32'd0);
         if (n == 3) chk("first_valid_latency", 32'(txv_v[d]), 32'd1);
         if (snap && !snapped && got.size() >= 2 * BPR + HB + 1) begin
            regs[2] = 32'h2222_2222;
            regs[3] = 32'h3333_3333;
            snapped = 1'b1;
         end
         if (abort_at > 0 && got.size() == abort_at) begin
            rst = 1'b1;
            #1;
            chk("abort_valid", 32'(txv_v[d]), 32'd0);
            chk("abort_busy", 32'(busy_v[d]), 32'd0);
            chk("abort_sel", 32'(sel_v[d]), 32'd0);
            chk("abort_data", 32'(txd_v[d]), 32'd0);
            @(posedge clk); #1;
            rst = 1'b0;
            return;
         end
         if (done_v[d]) break;
         if (n >= 4000) begin
            chk("done_timeout", 32'(done_v[d]), 32'd1);
            return;
         end
      end
      chk("done_busy", 32'(busy_v[d]), 32'd0);
      chk("done_sel", 32'(sel_v[d]), 32'd0);
      chk("done_valid", 32'(txv_v[d]), 32'd0);
      if (mode == 0) chk("dump_cycles", 32'(n), 32'(exp_cycles));
      start_v[d] = poke;
      @(posedge clk); #1;
      start_v[d] = 1'b0;
      chk("done_width", 32'(done_v[d]), 32'd0);
      chk("idle_after_done", 32'(busy_v[d]), 32'd0);
      repeat (3) begin
         @(posedge clk); #1;
      end
      chk("still_idle", 32'(busy_v[d]), 32'd0);
      chk("done_pulses", 32'(done_cnt), 32'd1);
      chk("byte_count", 32'(got.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got.size(); i++)
         chk($sformatf("byte_%0d", i), 32'(got[i]), 32'(exp_q[i]));
   endtask

   initial begin
      rst      = 1'b1;
      tx_ready = 1'b0;
      for (int i = 0; i < 3; i++) start_v[i] = 1'b0;
      rand_regs();
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         chk("rst_busy", 32'(busy_v[i]), 32'd0);
         chk("rst_done", 32'(done_v[i]), 32'd0);
         chk("rst_sel", 32'(sel_v[i]), 32'd0);
         chk("rst_data", 32'(txd_v[i]), 32'd0);
         chk("rst_valid", 32'(txv_v[i]), 32'd0);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      // full default dump, ready tied high
      rand_regs();
      regs[1]  = 32'h1234_5678;
      regs[31] = 32'hDEAD_BEEF;
      cap = regs;
      run_dump(0, 0, 1'b0, 1'b0, 0);
      if (got.size() >= 32 * BPR) begin
         chk("r0_zero", 32'(got[HB]), 32'h00);
         chk("r1_msb", 32'(got[BPR + HB]), 32'h12);
         chk("r1_lsb", 32'(got[BPR + HB + 3]), 32'h78);
         chk("r31_msb", 32'(got[31 * BPR + HB]), 32'hDE);
         chk("r31_lsb", 32'(got[31 * BPR + HB + 3]), 32'hEF);
      end

      // snapshot: r2/r3 rewritten while r2 is on the wire; stray starts while busy and in DONE
      rand_regs();
      regs[2] = 32'h1111_1111;
      regs[3] = 32'h0BAD_F00D;
      cap = regs;
      cap[3] = 32'h3333_3333;
      run_dump(0, 1, 1'b1, 1'b1, 0);

      // reset after the 10th byte, then a complete fresh dump
      rand_regs();
      cap = regs;
      run_dump(0, 0, 1'b0, 1'b0, 10);
      rand_regs();
      cap = regs;
      run_dump(0, 1, 1'b0, 1'b0, 0);

      // narrow range with throttled sink
      regs[5] = 32'hA5A5_A5A5;
      regs[6] = 32'h0000_FFFF;
      cap = regs;
      run_dump(1, 2, 1'b0, 1'b0, 0);

      // single register range
      regs[7] = 32'hCAFE_F00D;
      cap = regs;
      run_dump(2, 1, 1'b0, 1'b0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
